// File: rtl/jt51_pkg.sv
// Shared constants for the JT51 CPU write port: register addresses, FSM states
// and the index of the single active level-update strobe.
package jt51_pkg;

   localparam logic [7:0] ADDR_TEST   = 8'h01;
   localparam logic [7:0] ADDR_KON    = 8'h08;
   localparam logic [7:0] ADDR_NOISE  = 8'h0F;
   localparam logic [7:0] ADDR_CLKA1  = 8'h10;
   localparam logic [7:0] ADDR_CLKA2  = 8'h11;
   localparam logic [7:0] ADDR_CLKB   = 8'h12;
   localparam logic [7:0] ADDR_TIMER  = 8'h14;
   localparam logic [7:0] ADDR_LFRQ   = 8'h18;
   localparam logic [7:0] ADDR_PMDAMD = 8'h19;
   localparam logic [7:0] ADDR_CTW    = 8'h1B;

   localparam logic [7:0] ADDR_RL     = 8'h20;
   localparam logic [7:0] ADDR_KC     = 8'h28;
   localparam logic [7:0] ADDR_KF     = 8'h30;
   localparam logic [7:0] ADDR_PMS    = 8'h38;
   localparam logic [7:0] ADDR_DT1    = 8'h40;
   localparam logic [7:0] ADDR_TL     = 8'h60;
   localparam logic [7:0] ADDR_KS     = 8'h80;
   localparam logic [7:0] ADDR_AMSEN  = 8'hA0;
   localparam logic [7:0] ADDR_DT2    = 8'hC0;
   localparam logic [7:0] ADDR_D1L    = 8'hE0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_REL  = 2'd3;

   typedef enum logic [3:0] {
      UP_NONE  = 4'd0,
      UP_RL    = 4'd1,
      UP_KC    = 4'd2,
      UP_KF    = 4'd3,
      UP_PMS   = 4'd4,
      UP_DT1   = 4'd5,
      UP_TL    = 4'd6,
      UP_KS    = 4'd7,
      UP_AMSEN = 4'd8,
      UP_DT2   = 4'd9,
      UP_D1L   = 4'd10,
      UP_KON   = 4'd11
   } up_idx_t;

endpackage

// File: rtl/jt51_mmr_dec.sv
// Address decoder: which update strobe a data write selects, and whether the
// address is one of the global registers held in the front end.
module jt51_mmr_dec
   import jt51_pkg::*;
(
   input  logic [7:0] addr,
   output up_idx_t    up_idx,
   output logic       is_global,
   output logic       is_mapped
);

   always_comb begin
      up_idx    = UP_NONE;
      is_global = 1'b0;
      case (addr)
         ADDR_TEST, ADDR_NOISE, ADDR_CLKA1, ADDR_CLKA2, ADDR_CLKB,
         ADDR_TIMER, ADDR_LFRQ, ADDR_PMDAMD, ADDR_CTW: is_global = 1'b1;
         ADDR_KON: up_idx = UP_KON;
         default: ;
      endcase
      // Ranges are contiguous and ascending, so test from the top down.
      if      (addr >= ADDR_D1L)   up_idx = UP_D1L;
      else if (addr >= ADDR_DT2)   up_idx = UP_DT2;
      else if (addr >= ADDR_AMSEN) up_idx = UP_AMSEN;
      else if (addr >= ADDR_KS)    up_idx = UP_KS;
      else if (addr >= ADDR_TL)    up_idx = UP_TL;
      else if (addr >= ADDR_DT1)   up_idx = UP_DT1;
      else if (addr >= ADDR_PMS)   up_idx = UP_PMS;
      else if (addr >= ADDR_KF)    up_idx = UP_KF;
      else if (addr >= ADDR_KC)    up_idx = UP_KC;
      else if (addr >= ADDR_RL)    up_idx = UP_RL;
      is_mapped = is_global | (up_idx != UP_NONE);
   end

endmodule

// File: rtl/jt51_mmr.sv
// JT51 CPU write port: latches the address, holds one update strobe plus
// op/ch/data through a register-file sweep, and keeps the global registers.
module jt51_mmr
   import jt51_pkg::*;
#(
   parameter int SWEEP_TO = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       flag_A,
   input  logic       flag_B,
   input  logic       reg_busy,
   output logic [7:0] d_out,
   output logic [1:0] op,
   output logic [2:0] ch,
   output logic       up_rl,
   output logic       up_kc,
   output logic       up_kf,
   output logic       up_pms,
   output logic       up_dt1,
   output logic       up_tl,
   output logic       up_ks,
   output logic       up_amsen,
   output logic       up_dt2,
   output logic       up_d1l,
   output logic       up_kon,
   output logic       busy,
   output logic       csm,
   output logic       load_A,
   output logic       load_B,
   output logic       enable_irq_A,
   output logic       enable_irq_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic [9:0] value_A,
   output logic [7:0] value_B,
   output logic       lfo_rst,
   output logic [7:0] lfo_freq,
   output logic [6:0] lfo_amd,
   output logic [6:0] lfo_pmd,
   output logic [1:0] lfo_w,
   output logic       ct1,
   output logic       ct2,
   output logic       noise_en,
   output logic [4:0] nfreq,
   output logic [7:0] addr,
   output logic [1:0] state
);

   localparam int CW = $clog2(SWEEP_TO + 1);

   // Handshake: a bus write is one cs_n/wr_n low window; only its first
   // cycle (wr_now rising) is acted on, so a long strobe writes exactly once.
   logic          wr_now, wr_last, wr_acc;
   logic [CW-1:0] cnt;
   up_idx_t       up_sel, up_dec;
   logic          is_global, is_mapped;

   assign wr_now = !cs_n && !wr_n;
   assign wr_acc = wr_now && !wr_last;

   jt51_mmr_dec u_dec (
      .addr      (addr),
      .up_idx    (up_dec),
      .is_global (is_global),
      .is_mapped (is_mapped)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_last      <= 1'b0;
         addr         <= 8'd0;
         state        <= ST_IDLE;
         cnt          <= '0;
         up_sel       <= UP_NONE;
         d_out        <= 8'd0;
         op           <= 2'd0;
         ch           <= 3'd0;
         csm          <= 1'b0;
         load_A       <= 1'b0;
         load_B       <= 1'b0;
         enable_irq_A <= 1'b0;
         enable_irq_B <= 1'b0;
         clr_flag_A   <= 1'b0;
         clr_flag_B   <= 1'b0;
         value_A      <= 10'd0;
         value_B      <= 8'd0;
         lfo_rst      <= 1'b0;
         lfo_freq     <= 8'd0;
         lfo_amd      <= 7'd0;
         lfo_pmd      <= 7'd0;
         lfo_w        <= 2'd0;
         ct1          <= 1'b0;
         ct2          <= 1'b0;
         noise_en     <= 1'b0;
         nfreq        <= 5'd0;
      end else begin
         wr_last    <= wr_now;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         if (wr_acc && !a0) addr <= din;
         case (state)
            ST_IDLE: begin
               if (wr_acc && a0 && is_mapped) begin
                  if (is_global) begin
                     case (addr)
                        ADDR_TEST:  lfo_rst <= din[1];
                        ADDR_NOISE: begin
                           noise_en <= din[7];
                           nfreq    <= din[4:0];
                        end
                        ADDR_CLKA1: value_A[9:2] <= din;
                        ADDR_CLKA2: value_A[1:0] <= din[1:0];
                        ADDR_CLKB:  value_B <= din;
                        ADDR_TIMER: begin
                           csm          <= din[7];
                           load_A       <= din[0];
                           load_B       <= din[1];
                           enable_irq_A <= din[2];
                           enable_irq_B <= din[3];
                           clr_flag_A   <= din[4];
                           clr_flag_B   <= din[5];
                        end
                        ADDR_LFRQ:  lfo_freq <= din;
                        ADDR_PMDAMD: begin
                           if (din[7]) lfo_pmd <= din[6:0];
                           else        lfo_amd <= din[6:0];
                        end
                        ADDR_CTW: begin
                           lfo_w <= din[1:0];
                           ct1   <= din[6];
                           ct2   <= din[7];
                        end
                        default: ;
                     endcase
                  end else begin
                     d_out  <= din;
                     op     <= addr[4:3];
                     ch     <= (up_dec == UP_KON) ? din[2:0] : addr[2:0];
                     up_sel <= up_dec;
                     cnt    <= '0;
                     state  <= ST_ARM;
                  end
               end
            end
            ST_ARM: begin
               if (reg_busy) begin
                  state <= ST_WAIT;
               end else if (cnt == CW'(SWEEP_TO - 1)) begin
                  state  <= ST_REL;
                  up_sel <= UP_NONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_WAIT: begin
               if (!reg_busy) begin
                  state  <= ST_REL;
                  up_sel <= UP_NONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes decode from one index register, so at most one is ever high.
   assign up_rl    = (up_sel == UP_RL);
   assign up_kc    = (up_sel == UP_KC);
   assign up_kf    = (up_sel == UP_KF);
   assign up_pms   = (up_sel == UP_PMS);
   assign up_dt1   = (up_sel == UP_DT1);
   assign up_tl    = (up_sel == UP_TL);
   assign up_ks    = (up_sel == UP_KS);
   assign up_amsen = (up_sel == UP_AMSEN);
   assign up_dt2   = (up_sel == UP_DT2);
   assign up_d1l   = (up_sel == UP_D1L);
   assign up_kon   = (up_sel == UP_KON);

   assign busy = (state != ST_IDLE) || reg_busy;
   assign dout = {busy, 5'b0, flag_B, flag_A};

endmodule

// File: tb/tb_jt51_mmr.sv
// Directed bench for jt51_mmr: bus writes, sweep handshake, globals, reset.
module tb_jt51_mmr;

   logic       clk = 1'b0;
   logic       rst, cs_n, wr_n, a0, flag_A, flag_B, reg_busy;
   logic [7:0] din, dout, d_out, value_B, lfo_freq, addr;
   logic [1:0] op, lfo_w, state;
   logic [2:0] ch;
   logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_kon;
   logic       busy, csm, load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B;
   logic [9:0] value_A;
   logic [6:0] lfo_amd, lfo_pmd;
   logic       lfo_rst, ct1, ct2, noise_en;
   logic [4:0] nfreq;
   logic [10:0] ups;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign ups = {up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_kon};

   jt51_mmr #(.SWEEP_TO(3)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din), .dout(dout),
      .flag_A(flag_A), .flag_B(flag_B), .reg_busy(reg_busy), .d_out(d_out), .op(op), .ch(ch),
      .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
      .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2), .up_d1l(up_d1l),
      .up_kon(up_kon), .busy(busy), .csm(csm), .load_A(load_A), .load_B(load_B),
      .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B), .clr_flag_A(clr_flag_A),
      .clr_flag_B(clr_flag_B), .value_A(value_A), .value_B(value_B), .lfo_rst(lfo_rst),
      .lfo_freq(lfo_freq), .lfo_amd(lfo_amd), .lfo_pmd(lfo_pmd), .lfo_w(lfo_w), .ct1(ct1),
      .ct2(ct2), .noise_en(noise_en), .nfreq(nfreq), .addr(addr), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a write starting now (at a negedge); returns at the negedge
   // just after the accepting posedge with the strobe released.
   task automatic wr_at(input logic p, input logic [7:0] d);
      cs_n = 1'b0; wr_n = 1'b0; a0 = p; din = d;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic wr(input logic p, input logic [7:0] d);
      @(negedge clk);
      wr_at(p, d);
   endtask

   initial begin
      rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
      flag_A = 1'b0; flag_B = 1'b0; reg_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout", dout, 8'h00);
      chk("rst_ups", ups, 11'h000);
      chk("rst_state", state, 2'd0);
      chk("rst_dout_reg", d_out, 8'h00);
      chk("rst_value_A", value_A, 10'h000);
      rst = 1'b0;

      // KC sweep with reg_busy handshake
      wr(1'b0, 8'h28);
      wr(1'b1, 8'h4A);
      chk("kc_ups", ups, 11'h200);
      chk("kc_ch", ch, 3'd0);
      chk("kc_d_out", d_out, 8'h4A);
      chk("kc_busy", busy, 1'b1);
      chk("kc_state_arm", state, 2'd1);
      reg_busy = 1'b1;
      @(negedge clk);
      chk("kc_state_wait", state, 2'd2);
      repeat (4) @(negedge clk);
      chk("kc_hold_ups", ups, 11'h200);
      chk("kc_hold_d_out", d_out, 8'h4A);
      reg_busy = 1'b0;
      @(negedge clk);
      chk("kc_rel_ups", ups, 11'h000);
      chk("kc_rel_state", state, 2'd3);
      chk("kc_rel_busy", busy, 1'b1);
      @(negedge clk);
      chk("kc_idle_busy", busy, 1'b0);
      chk("kc_idle_state", state, 2'd0);

      // KON with channel from data, plus a dropped write during the sweep
      flag_A = 1'b1;
      wr(1'b0, 8'h08);
      wr(1'b1, 8'h7B);
      chk("kon_ups", ups, 11'h001);
      chk("kon_ch", ch, 3'd3);
      chk("kon_d_out", d_out, 8'h7B);
      chk("kon_dout_status", dout, 8'h81);
      reg_busy = 1'b1;
      wr(1'b0, 8'h60);
      wr(1'b1, 8'h11);
      chk("drop_addr", addr, 8'h60);
      chk("drop_ups", ups, 11'h001);
      chk("drop_d_out", d_out, 8'h7B);
      chk("drop_state", state, 2'd2);
      reg_busy = 1'b0;
      repeat (2) @(negedge clk);
      chk("kon_idle_ups", ups, 11'h000);
      chk("kon_idle_dout", dout, 8'h01);

      // Timer globals
      flag_A = 1'b0;
      wr(1'b0, 8'h10); wr(1'b1, 8'hC8);
      chk("ta_busy1", busy, 1'b0);
      wr(1'b0, 8'h11); wr(1'b1, 8'h03);
      chk("value_A", value_A, 10'h323);
      chk("ta_busy2", busy, 1'b0);
      wr(1'b0, 8'h14); wr(1'b1, 8'h35);
      chk("clr_A_pulse", clr_flag_A, 1'b1);
      chk("clr_B_pulse", clr_flag_B, 1'b1);
      chk("timer_ctl", {csm, enable_irq_B, enable_irq_A, load_B, load_A}, 5'b00101);
      chk("timer_busy", busy, 1'b0);
      chk("timer_state", state, 2'd0);
      @(negedge clk);
      chk("clr_B_end", clr_flag_B, 1'b0);
      chk("clr_A_end", clr_flag_A, 1'b0);

      // LFO and misc globals
      wr(1'b0, 8'h19); wr(1'b1, 8'h85);
      wr(1'b1, 8'h22);
      chk("lfo_pmd", lfo_pmd, 7'h05);
      chk("lfo_amd", lfo_amd, 7'h22);
      wr(1'b0, 8'h0F); wr(1'b1, 8'h9A);
      chk("noise", {noise_en, nfreq}, 6'b1_11010);
      wr(1'b0, 8'h1B); wr(1'b1, 8'hC2);
      chk("ctw", {ct2, ct1, lfo_w}, 4'b1110);
      wr(1'b0, 8'h18); wr(1'b1, 8'h55);
      chk("lfo_freq", lfo_freq, 8'h55);
      wr(1'b0, 8'h12); wr(1'b1, 8'h77);
      chk("value_B", value_B, 8'h77);
      wr(1'b0, 8'h01); wr(1'b1, 8'h02);
      chk("lfo_rst", lfo_rst, 1'b1);
      wr(1'b0, 8'h02); wr(1'b1, 8'hFF);
      chk("unmapped_busy", busy, 1'b0);
      chk("unmapped_ups", ups, 11'h000);
      chk("unmapped_lfo", {lfo_pmd, lfo_amd}, {7'h05, 7'h22});
      chk("unmapped_value_A", value_A, 10'h323);
      chk("unmapped_d_out", d_out, 8'h7B);

      // D1L sweep timing out without reg_busy, then a write on the REL->IDLE edge
      wr(1'b0, 8'hE5);
      wr(1'b1, 8'hF3);
      chk("d1l_opch", {op, ch}, 5'b00_101);
      for (int i = 0; i < 3; i++) begin
         chk("d1l_high", ups, 11'h002);
         @(negedge clk);
      end
      chk("d1l_rel_ups", ups, 11'h000);
      chk("d1l_rel_state", state, 2'd3);
      wr_at(1'b1, 8'h44);
      chk("rel_edge_state", state, 2'd0);
      chk("rel_edge_ups", ups, 11'h000);
      chk("rel_edge_busy", busy, 1'b0);
      chk("rel_edge_d_out", d_out, 8'hF3);

      // Reset during WAIT
      wr(1'b0, 8'h20);
      wr(1'b1, 8'h0C);
      chk("rl_ups", ups, 11'h400);
      reg_busy = 1'b1;
      @(negedge clk);
      chk("rl_wait", state, 2'd2);
      rst = 1'b1;
      reg_busy = 1'b0;
      @(negedge clk);
      chk("rst2_ups", ups, 11'h000);
      chk("rst2_d_out", d_out, 8'h00);
      chk("rst2_state", state, 2'd0);
      chk("rst2_addr", addr, 8'h00);
      chk("rst2_dout", dout, 8'h00);
      chk("rst2_globals", {value_A, lfo_pmd, lfo_amd, value_B}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
